// File: rtl/compactador_constante.sv
// compactador_constante
//
// Immediate compactor. Takes 16-bit data literals or jump offsets and picks
// the smallest constant-extender format that re-expands to the exact value.
// The result is the 3-bit extender control code plus the 12-bit constant
// field. A data literal that fits no single format is emitted as two beats:
// a high byte (code 010) followed by a low byte (code 001). The downstream
// side ORs the two expanded results back together.
//
// Optional feature macro: COMPACTADOR_SPLIT_EN
//   defined   - two-beat high/low split for data literals that fit no format
//   undefined - such literals produce a single error beat
//
// Handshake: a beat moves across an interface on a rising clock edge where
// its valid and ready are both high. valid, once raised, stays high and the
// payload stays stable until that transfer happens.
//
// Ports
//   clock         in   rising-edge clock
//   reset         in   synchronous, active-high
//   valor[15:0]   in   value to compact
//   tipo          in   0 = data literal, 1 = jump offset
//   valor_valido  in   input beat valid
//   pronto        out  input ready
//   controle[2:0] out  extender control code
//   constante[11:0] out constant field
//   saida_valida  out  output beat valid
//   saida_pronta  in   downstream ready
//   ultimo        out  last beat of the current value
//   erro          out  value not representable
module compactador_constante (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] valor,
    input  logic        tipo,
    input  logic        valor_valido,
    output logic        pronto,
    output logic [2:0]  controle,
    output logic [11:0] constante,
    output logic        saida_valida,
    input  logic        saida_pronta,
    output logic        ultimo,
    output logic        erro
);

`ifdef COMPACTADOR_SPLIT_EN
    typedef enum logic [1:0] {VAZIO = 2'd0, UNICO = 2'd1, ALTO = 2'd2, BAIXO = 2'd3} estado_t;
`else
    typedef enum logic [1:0] {VAZIO = 2'd0, UNICO = 2'd1, ALTO = 2'd2} estado_t;
`endif

    estado_t     estado, estado_prox;
    logic        valida_r, valida_prox;
    logic [2:0]  controle_r, controle_prox;
    logic [11:0] constante_r, constante_prox;
    logic        ultimo_r, ultimo_prox;
    logic        erro_r, erro_prox;
`ifdef COMPACTADOR_SPLIT_EN
    logic [7:0]  baixo_r, baixo_prox;
`endif

    // Format chosen for the value currently on the input.
    logic [2:0]  cls_controle;
    logic [11:0] cls_constante;
    logic        cls_erro;
    logic        cls_divide;

    logic aceita;
    logic transfere;
    logic pode_substituir;

    always_comb begin
        cls_controle  = 3'b111;
        cls_constante = 12'h000;
        cls_erro      = 1'b1;
        cls_divide    = 1'b0;
        if (!tipo) begin
            if (valor[15:11] == {5{valor[10]}}) begin
                cls_controle  = 3'b000;
                cls_constante = {1'b0, valor[10:0]};
                cls_erro      = 1'b0;
            end else if (valor[15:12] == 4'h0) begin
                cls_controle  = 3'b001;
                cls_constante = valor[11:0];
                cls_erro      = 1'b0;
            end else if (valor[7:0] == 8'h00) begin
                cls_controle  = 3'b010;
                cls_constante = {4'h0, valor[15:8]};
                cls_erro      = 1'b0;
            end else begin
`ifdef COMPACTADOR_SPLIT_EN
                // High beat first; the low byte is parked for the second beat.
                cls_controle  = 3'b010;
                cls_constante = {4'h0, valor[15:8]};
                cls_erro      = 1'b0;
                cls_divide    = 1'b1;
`endif
            end
        end else begin
            if (valor[15:8] == {8{valor[7]}}) begin
                cls_controle  = 3'b011;
                cls_constante = {4'h0, valor[7:0]};
                cls_erro      = 1'b0;
            end else if (valor[15:12] == {4{valor[11]}}) begin
                cls_controle  = 3'b100;
                cls_constante = valor[11:0];
                cls_erro      = 1'b0;
            end
        end
    end

    // A held final beat may be replaced in the same cycle it leaves.
`ifdef COMPACTADOR_SPLIT_EN
    assign pode_substituir = (estado == UNICO) || (estado == BAIXO);
`else
    assign pode_substituir = (estado == UNICO);
`endif

    assign pronto    = !reset && ((estado == VAZIO) || (pode_substituir && saida_pronta));
    assign aceita    = valor_valido && pronto;
    assign transfere = valida_r && saida_pronta;

    always_comb begin
        estado_prox    = estado;
        valida_prox    = valida_r;
        controle_prox  = controle_r;
        constante_prox = constante_r;
        ultimo_prox    = ultimo_r;
        erro_prox      = erro_r;
`ifdef COMPACTADOR_SPLIT_EN
        baixo_prox     = baixo_r;
`endif
        if (aceita) begin
            // Only reachable from VAZIO or a final beat that is leaving now.
            estado_prox    = cls_divide ? ALTO : UNICO;
            valida_prox    = 1'b1;
            controle_prox  = cls_controle;
            constante_prox = cls_constante;
            ultimo_prox    = !cls_divide;
            erro_prox      = cls_erro;
`ifdef COMPACTADOR_SPLIT_EN
            baixo_prox     = valor[7:0];
`endif
        end else if (transfere) begin
            case (estado)
`ifdef COMPACTADOR_SPLIT_EN
                ALTO: begin
                    estado_prox    = BAIXO;
                    controle_prox  = 3'b001;
                    constante_prox = {4'h0, baixo_r};
                    ultimo_prox    = 1'b1;
                    erro_prox      = 1'b0;
                end
`endif
                default: begin
                    estado_prox = VAZIO;
                    valida_prox = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            estado      <= VAZIO;
            valida_r    <= 1'b0;
            controle_r  <= 3'b000;
            constante_r <= 12'h000;
            ultimo_r    <= 1'b0;
            erro_r      <= 1'b0;
`ifdef COMPACTADOR_SPLIT_EN
            baixo_r     <= 8'h00;
`endif
        end else begin
            estado      <= estado_prox;
            valida_r    <= valida_prox;
            controle_r  <= controle_prox;
            constante_r <= constante_prox;
            ultimo_r    <= ultimo_prox;
            erro_r      <= erro_prox;
`ifdef COMPACTADOR_SPLIT_EN
            baixo_r     <= baixo_prox;
`endif
        end
    end

    assign saida_valida = valida_r;
    assign controle     = controle_r;
    assign constante    = constante_r;
    assign ultimo       = ultimo_r;
    assign erro         = erro_r;

endmodule

// File: tb/tb_compactador_constante.sv
// Bench for compactador_constante: directed scenarios with hand-computed
// expectations, then a handshake-toggling stream whose beats are re-expanded
// with the extender rules and compared against the values sent.
module tb_compactador_constante;

    logic        clock = 1'b0;
    logic        reset;
    logic [15:0] valor;
    logic        tipo;
    logic        valor_valido;
    logic        pronto;
    logic [2:0]  controle;
    logic [11:0] constante;
    logic        saida_valida;
    logic        saida_pronta;
    logic        ultimo;
    logic        erro;

    int checks   = 0;
    int failures = 0;

    logic [16:0] exp_q[$];

    // {saida_valida, controle, constante, ultimo, erro}
    logic [17:0] obs;
    assign obs = {saida_valida, controle, constante, ultimo, erro};

`ifdef COMPACTADOR_SPLIT_EN
    localparam bit SPLIT_EN = 1'b1;
`else
    localparam bit SPLIT_EN = 1'b0;
`endif

    compactador_constante dut (
        .clock        (clock),
        .reset        (reset),
        .valor        (valor),
        .tipo         (tipo),
        .valor_valido (valor_valido),
        .pronto       (pronto),
        .controle     (controle),
        .constante    (constante),
        .saida_valida (saida_valida),
        .saida_pronta (saida_pronta),
        .ultimo       (ultimo),
        .erro         (erro)
    );

    // ---------------- clock / reset ----------------
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    // Extender rules, as the datapath re-expands each format.
    function automatic logic [15:0] expande(input logic [2:0] c, input logic [11:0] k);
        case (c)
            3'b000:  expande = {{5{k[10]}}, k[10:0]};
            3'b001:  expande = {4'h0, k};
            3'b010:  expande = {k[7:0], 8'h00};
            3'b011:  expande = {{8{k[7]}}, k[7:0]};
            3'b100:  expande = {{4{k[11]}}, k};
            default: expande = 16'h0000;
        endcase
    endfunction

    // A value is an error when no single format round-trips it (and, for
    // data, the split is not available).
    function automatic logic erro_esperado(input logic t, input logic [15:0] v);
        logic cabe;
        if (!t) begin
            cabe = (expande(3'b000, {1'b0, v[10:0]}) == v) ||
                   (expande(3'b001, v[11:0]) == v) ||
                   (expande(3'b010, {4'h0, v[15:8]}) == v);
            erro_esperado = !cabe && !SPLIT_EN;
        end else begin
            cabe = (expande(3'b011, {4'h0, v[7:0]}) == v) ||
                   (expande(3'b100, v[11:0]) == v);
            erro_esperado = !cabe;
        end
    endfunction

    // ---------------- scenarios ----------------
    task automatic test_reset;
        reset        = 1'b1;
        valor        = 16'h0005;
        tipo         = 1'b0;
        valor_valido = 1'b1;
        saida_pronta = 1'b1;
        repeat (3) tick();
        checks++;
        if (obs !== 18'h0) begin
            failures++;
            $display("FAIL reset_outputs got=%h want=%h", obs, 18'h0);
        end
        checks++;
        if (pronto !== 1'b0) begin
            failures++;
            $display("FAIL reset_pronto got=%b want=0", pronto);
        end
        reset        = 1'b0;
        valor_valido = 1'b0;
        #1;
        checks++;
        if (pronto !== 1'b1) begin
            failures++;
            $display("FAIL pronto_after_reset got=%b want=1", pronto);
        end
    endtask

    task automatic test_single;
        valor = 16'hFC00; tipo = 1'b0; valor_valido = 1'b1; saida_pronta = 1'b1;
        tick();
        valor_valido = 1'b0;
        checks++;
        if (obs !== {1'b1, 3'b000, 12'h400, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL single_fc00 got=%h want=%h", obs, {1'b1, 3'b000, 12'h400, 1'b1, 1'b0});
        end
        tick();
        checks++;
        if (saida_valida !== 1'b0) begin
            failures++;
            $display("FAIL single_drain got=%b want=0", saida_valida);
        end
    endtask

    task automatic test_back_to_back;
        valor = 16'h0ABC; tipo = 1'b0; valor_valido = 1'b1; saida_pronta = 1'b1;
        tick();
        checks++;
        if (obs !== {1'b1, 3'b001, 12'hABC, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL b2b_0abc got=%h want=%h", obs, {1'b1, 3'b001, 12'hABC, 1'b1, 1'b0});
        end
        valor = 16'h7F00;
        #1;
        checks++;
        if (pronto !== 1'b1) begin
            failures++;
            $display("FAIL b2b_pronto got=%b want=1", pronto);
        end
        tick();
        valor_valido = 1'b0;
        checks++;
        if (obs !== {1'b1, 3'b010, 12'h07F, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL b2b_7f00 got=%h want=%h", obs, {1'b1, 3'b010, 12'h07F, 1'b1, 1'b0});
        end
        tick();
        checks++;
        if (saida_valida !== 1'b0) begin
            failures++;
            $display("FAIL b2b_drain got=%b want=0", saida_valida);
        end
    endtask

    task automatic test_split;
        logic [17:0] want1;
        valor = 16'h1234; tipo = 1'b0; valor_valido = 1'b1; saida_pronta = 1'b0;
        tick();
        valor_valido = 1'b0;
        want1 = SPLIT_EN ? {1'b1, 3'b010, 12'h012, 1'b0, 1'b0}
                         : {1'b1, 3'b111, 12'h000, 1'b1, 1'b1};
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (obs !== want1) begin
                failures++;
                $display("FAIL split_hold%0d got=%h want=%h", i, obs, want1);
            end
            checks++;
            if (pronto !== 1'b0) begin
                failures++;
                $display("FAIL split_pronto%0d got=%b want=0", i, pronto);
            end
            if (i < 2) tick();
        end
        saida_pronta = 1'b1;
        tick();
        if (SPLIT_EN) begin
            checks++;
            if (obs !== {1'b1, 3'b001, 12'h034, 1'b1, 1'b0}) begin
                failures++;
                $display("FAIL split_low got=%h want=%h", obs, {1'b1, 3'b001, 12'h034, 1'b1, 1'b0});
            end
            tick();
        end
        checks++;
        if (saida_valida !== 1'b0) begin
            failures++;
            $display("FAIL split_drain got=%b want=0", saida_valida);
        end
    endtask

    task automatic test_jump;
        logic [15:0] vals [3];
        logic [17:0] want [3];
        vals = '{16'hFF80, 16'hF800, 16'h0800};
        want = '{{1'b1, 3'b011, 12'h080, 1'b1, 1'b0},
                 {1'b1, 3'b100, 12'h800, 1'b1, 1'b0},
                 {1'b1, 3'b111, 12'h000, 1'b1, 1'b1}};
        tipo = 1'b1; saida_pronta = 1'b1; valor_valido = 1'b1;
        for (int i = 0; i < 3; i++) begin
            valor = vals[i];
            tick();
            checks++;
            if (obs !== want[i]) begin
                failures++;
                $display("FAIL jump_%h got=%h want=%h", vals[i], obs, want[i]);
            end
        end
        valor_valido = 1'b0;
        tick();
        checks++;
        if (saida_valida !== 1'b0) begin
            failures++;
            $display("FAIL jump_drain got=%b want=0", saida_valida);
        end
    endtask

    task automatic test_reset_mid_split;
        valor = 16'h1234; tipo = 1'b0; valor_valido = 1'b1; saida_pronta = 1'b0;
        tick();
        valor_valido = 1'b0;
        reset        = 1'b1;
        tick();
        checks++;
        if (obs !== 18'h0) begin
            failures++;
            $display("FAIL midsplit_reset got=%h want=%h", obs, 18'h0);
        end
        reset = 1'b0;
        valor = 16'h0005; valor_valido = 1'b1; saida_pronta = 1'b1;
        tick();
        valor_valido = 1'b0;
        checks++;
        if (obs !== {1'b1, 3'b000, 12'h005, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL midsplit_next got=%h want=%h", obs, {1'b1, 3'b000, 12'h005, 1'b1, 1'b0});
        end
        tick();
        checks++;
        if (saida_valida !== 1'b0) begin
            failures++;
            $display("FAIL midsplit_stale got=%h want=%h", obs, 18'h0);
        end
    endtask

    task automatic test_stream;
        logic [16:0] tab [14];
        logic [16:0] e;
        logic [15:0] acc;
        logic        we;
        int          idx;
        int          rec;
        int          total;
        tab = '{{1'b0, 16'h0000}, {1'b0, 16'hFFFF}, {1'b0, 16'h0400}, {1'b0, 16'hABCD},
                {1'b0, 16'h8000}, {1'b0, 16'h00FF}, {1'b0, 16'hFC01}, {1'b0, 16'h7FFF},
                {1'b1, 16'h007F}, {1'b1, 16'hFF00}, {1'b1, 16'h07FF}, {1'b1, 16'h8000},
                {1'b1, 16'h1234}, {1'b0, 16'h1234}};
        total = 28;
        idx   = 0;
        rec   = 0;
        acc   = 16'h0000;
        for (int cyc = 0; cyc < 3000 && rec < total; cyc++) begin
            saida_pronta = ($urandom_range(0, 3) != 0);
            if (idx < total) begin
                if (!valor_valido) valor_valido = 1'($urandom_range(0, 1));
                {tipo, valor} = tab[idx % 14];
            end else begin
                valor_valido = 1'b0;
            end
            @(negedge clock);
            if (valor_valido && pronto) begin
                exp_q.push_back(tab[idx % 14]);
                idx++;
            end
            if (saida_valida && saida_pronta) begin
                acc = acc | expande(controle, constante);
                if (ultimo) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        failures++;
                        $display("FAIL stream_extra got=%h want=none", obs);
                    end else begin
                        e  = exp_q.pop_front();
                        we = erro_esperado(e[16], e[15:0]);
                        if (erro !== we || (!we && acc !== e[15:0])) begin
                            failures++;
                            $display("FAIL stream_value got=%h erro=%b want=%h erro=%b", acc, erro, e[15:0], we);
                        end
                    end
                    rec++;
                    acc = 16'h0000;
                end
            end
            @(posedge clock);
            #1;
            if (valor_valido && idx > 0 && !pronto) begin
                // keep holding the same beat until it is taken
            end
            if (valor_valido && (idx >= total || exp_q.size() > 0)) valor_valido = valor_valido;
        end
        valor_valido = 1'b0;
        checks++;
        if (rec != total) begin
            failures++;
            $display("FAIL stream_count got=%0d want=%0d", rec, total);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_split();
        test_jump();
        test_reset_mid_split();
        test_stream();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
